// File: rtl/uart_tx.sv
// UART transmitter: valid/ready into a one-deep holding register, LSB-first frames paced by cke.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] w);
        return ^w;
    endfunction
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
    } state_e;
`endif

    localparam logic [3:0] IDX_LAST  = 4'(DATA_BITS - 1);
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    state_e                 state_q, state_d;
    logic [DATA_BITS-1:0]   hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0]   shifter_q, shifter_d;
    logic [3:0]             bit_idx_q, bit_idx_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   load_s;
`ifdef UART_TX_PARITY_EN
    logic                   par_q, par_d;
`endif

    assign ready = rst_ && !hold_full_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

    // Next-state logic; tx_d/busy_d describe the state being entered so the line is registered.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shifter_d   = shifter_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        load_s      = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        if (valid && ready) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end else begin
            hold_d      = hold_q;
        end

        case (state_q)
            S_IDLE: begin
                if (cke && hold_full_q) begin
                    load_s = 1'b1;
                end else begin
                    tx_d   = 1'b1;
                end
            end
            S_START: begin
                if (cke) begin
                    state_d   = S_DATA;
                    bit_idx_d = 4'd0;
                    tx_d      = shifter_q[0];
                end else begin
                    tx_d      = 1'b0;
                end
            end
            S_DATA: begin
                if (cke) begin
                    shifter_d = shifter_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d    = S_PARITY;
                        tx_d       = par_q;
`else
                        state_d    = S_STOP;
                        stop_cnt_d = 1'b0;
                        tx_d       = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = shifter_q[1];
                    end
                end else begin
                    tx_d = shifter_q[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cke) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end else begin
                    tx_d       = par_q;
                end
            end
`endif
            S_STOP: begin
                if (cke) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // Chain straight into the next start bit when a word is waiting.
                        if (hold_full_q) begin
                            load_s  = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    tx_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load_s) begin
            shifter_d   = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_START;
            tx_d        = 1'b0;
            busy_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d       = even_parity(hold_q);
`endif
        end else begin
            shifter_d   = shifter_d;
        end
    end

    // State register with synchronous active-low reset; a reset aborts any frame and drops the held word.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shifter_q   <= '0;
            bit_idx_q   <= 4'd0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shifter_q   <= shifter_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

endmodule
